hit_input_sequencer: RTL
========================

# hit_input_sequencer

Upstream stage of the block-memory hit storage. Buffers incoming (SSID, hit info) words and event-end markers in a small FIFO. Presents hits to the storage block one per cycle with `newAddress`, honouring `storageReady`. At each event boundary it sequences the storage through drain, readout (`readMemory`/`readReady`) and clear (`clearMemory`/`storageReady`) before releasing the next event's hits.

## Interface
- `SSIDBITS`, default 16: SSID width, identical to the storage block's.
- `HITINFOBITS`, default 8: hit-info width, identical to the storage block's.
- `FIFODEPTH`, default 16: entries, power of two; `FIFOADDRBITS` = log2(`FIFODEPTH`).
- `DRAINCYCLES`, default 4: idle cycles that let the storage block's internal queues empty. Must be ≥ its queue size.
- `clock` in 1: single clock; all logic is on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `inValid` in 1: input word valid.
- `inEnd` in 1: input word is an event-end marker; `inSSID`/`inHitInfo` are ignored when it is set.
- `inSSID` in `SSIDBITS`: hit SSID.
- `inHitInfo` in `HITINFOBITS`: hit info.
- `inReady` out 1: FIFO can accept; a word transfers when `inValid && inReady`.
- `storageReady` in 1: from the storage block.
- `readReady` in 1: from the storage block.
- `newAddress` out 1: one-cycle strobe qualifying `SSID`/`hitInfo`.
- `SSID` out `SSIDBITS`: to the storage block.
- `hitInfo` out `HITINFOBITS`: to the storage block.
- `readMemory` out 1: one-cycle readout request.
- `clearMemory` out 1: one-cycle clear request.
- `eventCount` out 16: completed events; wraps 0xFFFF→0.
- `busy` out 1: high in every state except STREAM.

## Operation
- FIFO entries are {end, SSID, info}, `FIFODEPTH` deep, with an occupancy count of `FIFOADDRBITS`+1 bits. Pointers wrap modulo `FIFODEPTH`.
- `inReady` = (count < `FIFODEPTH`) && !reset. It depends only on the registered count, so there is no push when full, even if a pop happens in the same cycle. Simultaneous push and pop when not full leaves count unchanged. The FIFO keeps accepting in every state.
- All outputs are registered. Reset value: every output is 0, except `inReady`, which is 0 while `reset` is high. FIFO is emptied, `eventCount` = 0, state = CLEAR.
- States:
  - **CLEAR**: drive `clearMemory` = 1 for exactly one cycle, load guard = 2, go to CLR_WAIT.
  - **CLR_WAIT**: decrement guard to 0. Then, when `storageReady` = 1, go to STREAM. The guard is required because `storageReady` falls only one edge after `clearMemory` is sampled.
  - **STREAM**: if count > 0 and `storageReady` = 1, pop the head.
    - Hit entry: the next cycle drives `newAddress` = 1 with `SSID`/`hitInfo` = the entry; stay in STREAM. Back-to-back pops give one hit per cycle.
    - Marker entry: no strobe; load drain counter = `DRAINCYCLES`; go to DRAIN.
    - If `storageReady` = 0, no pop; `newAddress` = 0.
  - **DRAIN**: decrement the counter only on cycles where `storageReady` = 1. At 0, go to READ.
  - **READ**: drive `readMemory` = 1 for one cycle, guard = 2, go to RD_WAIT.
  - **RD_WAIT**: after the guard expires, when `readReady` = 1, increment `eventCount` and go to CLEAR.
- `SSID`/`hitInfo` hold their last value when `newAddress` = 0.
- At most one of `newAddress`, `readMemory`, `clearMemory` is high in any cycle.
- Consecutive markers produce empty events: each one runs DRAIN/READ/CLEAR and increments `eventCount`.
- `reset` asserted mid-operation: immediately zero outputs and flush the FIFO, including in-flight hits. On the first edge after release, enter CLEAR, so the memory is re-cleared.

## Timing
- Push into an empty FIFO at edge k (state STREAM, `storageReady` = 1): pop at edge k+1, `newAddress` high during cycle k+1→k+2. Latency is 2 cycles.
- Marker popped at edge m: `readMemory` high no earlier than the cycle after edge m+`DRAINCYCLES`+1.
- `clearMemory` follows the `readReady`-accepted edge by one cycle.
- After reset release, the first `newAddress` comes no earlier than 4 edges later: CLEAR, 2 guard cycles, then pop.

## Test plan
- Reset, then hold `storageReady` = 1 → one `clearMemory` pulse, `busy` falls. Push SSID 0x0012 / info 0x5A → `newAddress` exactly 2 cycles after the push, `SSID` = 0x0012, `hitInfo` = 0x5A.
- Push 16 hits back-to-back with `storageReady` forced to 0 → `inReady` = 0 after the 16th push and the 17th word is not accepted. Release `storageReady` → 16 consecutive `newAddress` cycles, in order.
- Push 3 hits then a marker, `DRAINCYCLES` = 4 → 3 strobes; `readMemory` 5+ cycles after the marker pop; on `readReady` = 1, `eventCount` = 1, then one `clearMemory` pulse, then STREAM.
- Drop `storageReady` to 0 for 3 cycles in the middle of a hit stream → no pops and no strobes during those cycles; order is preserved and no hits are lost or duplicated.
- Two markers back-to-back → two READ/CLEAR sequences, `eventCount` = 2, zero `newAddress` strobes.
- Assert `reset` during RD_WAIT with 5 entries in the FIFO → all outputs 0 immediately, count = 0. After release: a `clearMemory` pulse and `eventCount` = 0.

Source files
------------

// File: rtl/hit_input_sequencer.sv
// Front end of the block-memory hit storage: buffers hits and event-end markers,
// streams hits into storage, and runs drain/readout/clear at each event boundary.
module hit_input_sequencer #(
  parameter int SSIDBITS    = 16,
  parameter int HITINFOBITS = 8,
  parameter int FIFODEPTH   = 16,
  parameter int DRAINCYCLES = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inValid,
  input  logic                   inEnd,
  input  logic [SSIDBITS-1:0]    inSSID,
  input  logic [HITINFOBITS-1:0] inHitInfo,
  output logic                   inReady,
  input  logic                   storageReady,
  input  logic                   readReady,
  output logic                   newAddress,
  output logic [SSIDBITS-1:0]    SSID,
  output logic [HITINFOBITS-1:0] hitInfo,
  output logic                   readMemory,
  output logic                   clearMemory,
  output logic [15:0]            eventCount,
  output logic                   busy
);

  localparam int FIFOADDRBITS = $clog2(FIFODEPTH);
  localparam int ENTRYBITS    = 1 + SSIDBITS + HITINFOBITS;
  localparam int DRAINBITS    = (DRAINCYCLES < 2) ? 1 : $clog2(DRAINCYCLES + 1);

  typedef enum logic [2:0] {CLEAR, CLR_WAIT, STREAM, DRAIN, READ, RD_WAIT} state_t;

  state_t                  state, stateNext;
  logic [1:0]              guard, guardNext;
  logic [DRAINBITS-1:0]    drain, drainNext;
  logic [15:0]             eventCountNext;
  logic                    newAddressNext, readMemoryNext, clearMemoryNext, busyNext;
  logic [SSIDBITS-1:0]     ssidNext;
  logic [HITINFOBITS-1:0]  hitInfoNext;

  logic [ENTRYBITS-1:0]    fifoMem [FIFODEPTH];
  logic [FIFOADDRBITS-1:0] wrPtr, rdPtr;
  logic [FIFOADDRBITS:0]   fifoCount;
  logic                    push, pop;
  logic [ENTRYBITS-1:0]    headEntry;
  logic                    headEnd;
  logic [SSIDBITS-1:0]     headSSID;
  logic [HITINFOBITS-1:0]  headInfo;

  // Input stage: FIFO occupancy gates acceptance; a pop never frees a slot in the same cycle
  assign inReady = (fifoCount < (FIFOADDRBITS+1)'(FIFODEPTH)) && !reset;
  assign push    = inValid && inReady;
  assign headEntry = fifoMem[rdPtr];
  assign {headEnd, headSSID, headInfo} = headEntry;

  always_ff @(posedge clock) begin
    if (push) fifoMem[wrPtr] <= {inEnd, inSSID, inHitInfo};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (push) wrPtr <= wrPtr + 1'b1;
      if (pop)  rdPtr <= rdPtr + 1'b1;
      if (push && !pop)      fifoCount <= fifoCount + 1'b1;
      else if (pop && !push) fifoCount <= fifoCount - 1'b1;
    end
  end

  // Sequencing stage: decide the pop and the next registered outputs
  always_comb begin
    stateNext       = state;
    guardNext       = guard;
    drainNext       = drain;
    eventCountNext  = eventCount;
    newAddressNext  = 1'b0;
    readMemoryNext  = 1'b0;
    clearMemoryNext = 1'b0;
    ssidNext        = SSID;
    hitInfoNext     = hitInfo;
    pop             = 1'b0;
    unique case (state)
      CLEAR: begin
        clearMemoryNext = 1'b1;
        guardNext       = 2'd2;
        stateNext       = CLR_WAIT;
      end
      CLR_WAIT: begin
        // storageReady lags clearMemory by an edge, so it is not trusted until the guard expires
        if (guard != 2'd0)     guardNext = guard - 2'd1;
        else if (storageReady) stateNext = STREAM;
      end
      STREAM: begin
        if ((fifoCount != '0) && storageReady) begin
          pop = 1'b1;
          if (headEnd) begin
            drainNext = DRAINBITS'(DRAINCYCLES);
            stateNext = DRAIN;
          end else begin
            newAddressNext = 1'b1;
            ssidNext       = headSSID;
            hitInfoNext    = headInfo;
          end
        end
      end
      DRAIN: begin
        if (drain == '0)       stateNext = READ;
        else if (storageReady) drainNext = drain - 1'b1;
      end
      READ: begin
        readMemoryNext = 1'b1;
        guardNext      = 2'd2;
        stateNext      = RD_WAIT;
      end
      RD_WAIT: begin
        if (guard != 2'd0) guardNext = guard - 2'd1;
        else if (readReady) begin
          eventCountNext = eventCount + 16'd1;
          stateNext      = CLEAR;
        end
      end
      default: stateNext = CLEAR;
    endcase
    busyNext = (stateNext != STREAM);
  end

  // Output stage: every output leaves from a register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= CLEAR;
      guard       <= '0;
      drain       <= '0;
      eventCount  <= '0;
      newAddress  <= 1'b0;
      readMemory  <= 1'b0;
      clearMemory <= 1'b0;
      busy        <= 1'b0;
      SSID        <= '0;
      hitInfo     <= '0;
    end else begin
      state       <= stateNext;
      guard       <= guardNext;
      drain       <= drainNext;
      eventCount  <= eventCountNext;
      newAddress  <= newAddressNext;
      readMemory  <= readMemoryNext;
      clearMemory <= clearMemoryNext;
      busy        <= busyNext;
      SSID        <= ssidNext;
      hitInfo     <= hitInfoNext;
    end
  end

endmodule
